internal_node_sender: RTL and testbench

//  Transmit side of the internal-node load interface of the KD-tree.
//  - Accepts split-node words from the upstream loader (host/SRAM reader) over valid/ready.
//  - Buffers them in a 2-entry skid buffer.
//  - Drives them one per cycle onto sender_enable/sender_data, in breadth-first order.
//  - The KD-tree stores one word per sender_enable pulse, advancing its write address on each pulse.
//  - Exactly NUM_NODES words are sent per load; then done is raised.

---
 rtl/internal_node_sender.sv | 180 ++++++++++++++++++
 tb/tb_internal_node_sender.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/internal_node_sender.sv
// internal_node_sender: transmit side of the KD-tree internal-node load port.
// Upstream split-node words enter over valid/ready into a two-entry skid
// buffer and leave one per cycle as registered sender_enable/sender_data
// pulses. Exactly NUM_NODES words make up one load, after which done is held.
module internal_node_sender #(
   parameter int INTERNAL_WIDTH = 22,
   parameter int NUM_NODES      = 127,
   parameter int COUNT_WIDTH    = 7
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      pause,
   input  logic                      in_valid,
   input  logic [INTERNAL_WIDTH-1:0] in_data,
   output logic                      in_ready,
   output logic                      sender_enable,
   output logic [INTERNAL_WIDTH-1:0] sender_data,
   output logic [COUNT_WIDTH-1:0]    node_count,
   output logic                      busy,
   output logic                      done
);

   // Node total at counter width; COUNT_WIDTH is sized so this never truncates.
   localparam logic [COUNT_WIDTH-1:0] NODES_C = COUNT_WIDTH'(NUM_NODES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [1:0]                buf_cnt_q, buf_cnt_d;
   logic [INTERNAL_WIDTH-1:0] buf0_q, buf0_d;   // head of the skid buffer
   logic [INTERNAL_WIDTH-1:0] buf1_q, buf1_d;   // second entry, valid when count == 2
   logic [COUNT_WIDTH-1:0]    acc_cnt_q, acc_cnt_d;
   logic [COUNT_WIDTH-1:0]    node_count_q, node_count_d;
   logic                      sender_enable_q, sender_enable_d;
   logic [INTERNAL_WIDTH-1:0] sender_data_q, sender_data_d;

   logic push;
   logic pop;
   logic clear;
   logic ready_int;

   // Handshake and send qualifiers; all derive from registered state only,
   // so in_ready never depends combinationally on in_valid.
   always_comb begin
      ready_int = (state_q == S_STREAM) && (buf_cnt_q < 2'd2) && (acc_cnt_q < NODES_C);
      push      = in_valid && ready_int && !abort;
      pop       = (state_q == S_STREAM) && !pause && (buf_cnt_q != 2'd0) && !abort;
   end

   // Load sequencing: abort wins over everything, start is only honoured
   // outside STREAM, and DONE follows the cycle showing the final pulse.
   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         clear   = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_STREAM;
                  clear   = 1'b1;
               end
            end
            S_STREAM: begin
               if (node_count_q == NODES_C) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (start) begin
                  state_d = S_STREAM;
                  clear   = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               clear   = 1'b1;
            end
         endcase
      end
   end

   // Counters and the registered output pulse. Counters stop at NUM_NODES
   // because acceptance is gated by acc_cnt and sends cannot outrun accepts.
   always_comb begin
      acc_cnt_d       = acc_cnt_q;
      node_count_d    = node_count_q;
      buf_cnt_d       = buf_cnt_q;
      sender_enable_d = pop;
      sender_data_d   = sender_data_q;
      if (clear) begin
         acc_cnt_d    = '0;
         node_count_d = '0;
         buf_cnt_d    = '0;
      end else begin
         if (push) begin
            acc_cnt_d = acc_cnt_q + COUNT_WIDTH'(1);
         end
         if (pop) begin
            node_count_d  = node_count_q + COUNT_WIDTH'(1);
            sender_data_d = buf0_q;
         end
         buf_cnt_d = buf_cnt_q + 2'(push) - 2'(pop);
      end
   end

   // Skid buffer storage: a pop shifts entry 1 into the head, a push lands
   // in the first slot that is free after any pop in the same cycle.
   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      case ({push, pop})
         2'b10: begin
            if (buf_cnt_q == 2'd0) begin
               buf0_d = in_data;
            end else begin
               buf1_d = in_data;
            end
         end
         2'b01: begin
            buf0_d = buf1_q;
         end
         2'b11: begin
            if (buf_cnt_q == 2'd1) begin
               buf0_d = in_data;
            end else begin
               buf0_d = buf1_q;
               buf1_d = in_data;
            end
         end
         default: begin
            buf0_d = buf0_q;
         end
      endcase
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         buf_cnt_q       <= '0;
         acc_cnt_q       <= '0;
         node_count_q    <= '0;
         sender_enable_q <= 1'b0;
         sender_data_q   <= '0;
      end else begin
         state_q         <= state_d;
         buf_cnt_q       <= buf_cnt_d;
         acc_cnt_q       <= acc_cnt_d;
         node_count_q    <= node_count_d;
         sender_enable_q <= sender_enable_d;
         sender_data_q   <= sender_data_d;
      end
   end

   // Buffer payload needs no reset; buf_cnt_q alone says which entries are live.
   always_ff @(posedge clk) begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
   end

   // Output mapping.
   always_comb begin
      in_ready      = ready_int;
      sender_enable = sender_enable_q;
      sender_data   = sender_data_q;
      node_count    = node_count_q;
      busy          = (state_q == S_STREAM);
      done          = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_internal_node_sender.sv
// Testbench for internal_node_sender: directed load scenarios plus random
// valid/pause/abort traffic, compared cycle by cycle against a queue model.
module tb_internal_node_sender;

   localparam int W = 22;
   localparam int N = 127;
   localparam int CW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          pause = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready;
   logic          sender_enable;
   logic [W-1:0]  sender_data;
   logic [CW-1:0] node_count;
   logic          busy;
   logic          done;

   internal_node_sender #(
      .INTERNAL_WIDTH(W),
      .NUM_NODES(N),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .pause(pause),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .sender_enable(sender_enable),
      .sender_data(sender_data),
      .node_count(node_count),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: mode 0 idle, 1 loading, 2 finished; q holds words
   // accepted but not yet handed to the tree.
   int           m_mode = 0;
   logic [W-1:0] q[$];
   int           m_acc = 0;
   int           m_sent = 0;
   bit           m_en = 0;
   logic [W-1:0] m_data = '0;
   bit           m_push = 0;

   // Bench bookkeeping per load.
   bit seq_on = 0;
   int word_idx = 0;
   int seq_next = 0;
   int pulses = 0;
   int cyc = 0;
   int first_cyc = 0;
   int last_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, wanted %0d", tag, obs, exp);
   endtask

   function automatic bit m_ready();
      return (m_mode == 1) && (q.size() < 2) && (m_acc < N);
   endfunction

   task automatic load_clear();
      q.delete();
      m_acc = 0;
      m_sent = 0;
      word_idx = 0;
      seq_next = 0;
      pulses = 0;
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_en = 0;
      m_data = '0;
      load_clear();
   endtask

   task automatic model_step();
      bit pop;
      int sent_old;
      pop = (m_mode == 1) && !pause && (q.size() > 0) && !abort;
      m_push = in_valid && m_ready() && !abort;
      if (abort) begin
         m_mode = 0;
         m_en = 0;
         load_clear();
      end else begin
         sent_old = m_sent;
         m_en = pop;
         if (pop) begin
            m_data = q.pop_front();
            m_sent++;
         end
         if (m_push) begin
            q.push_back(in_data);
            m_acc++;
            word_idx++;
         end
         case (m_mode)
            0: if (start) begin m_mode = 1; load_clear(); end
            1: if (sent_old == N) m_mode = 2;
            default: if (start) begin m_mode = 1; load_clear(); end
         endcase
      end
   endtask

   // One clock: inputs are already applied at the falling edge.
   task automatic tick();
      chk("in_ready", in_ready, m_ready());
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      chk("sender_enable", sender_enable, m_en);
      chk("sender_data", sender_data, m_data);
      chk("node_count", node_count, m_sent);
      chk("busy", busy, m_mode == 1);
      chk("done", done, m_mode == 2);
      if (sender_enable) begin
         pulses++;
         if (seq_on) begin
            chk("seq_data", sender_data, seq_next);
            seq_next++;
         end
         if (pulses == 1) first_cyc = cyc;
         last_cyc = cyc;
      end
      @(negedge clk);
   endtask

   task automatic drive_tick();
      if (seq_on) in_data = W'(word_idx);
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      drive_tick();
      start = 1'b0;
   endtask

   task automatic run_to_pulses(input int target, input string tag);
      int n;
      n = 0;
      while (pulses < target && n < 1000) begin
         drive_tick();
         n++;
      end
      chk(tag, pulses, target);
   endtask

   task automatic run_to_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 2000) begin
         drive_tick();
         n++;
      end
      chk(tag, done, 1);
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_enable", sender_enable, 0);
      chk("rst_data", sender_data, 0);
      chk("rst_count", node_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2) drive_tick();

      // Back-to-back full load with in_data = index
      seq_on = 1;
      in_valid = 1'b1;
      pulse_start();
      run_to_done("t1_done_reached");
      chk("t1_pulses", pulses, N);
      chk("t1_span", last_cyc - first_cyc, N - 1);
      chk("t1_node_count", node_count, N);

      // Start in DONE begins a new load; pause while full; start mid-stream ignored
      pulse_start();
      chk("t6_done_clear", done, 0);
      chk("t6_busy", busy, 1);
      run_to_pulses(10, "t2_pre_pause");
      pause = 1'b1;
      repeat (5) drive_tick();
      chk("t2_full_ready", in_ready, 0);
      pause = 1'b0;
      run_to_pulses(60, "t2_post_pause");
      pulse_start();
      chk("t6_ignored_busy", busy, 1);
      run_to_done("t2_done_reached");
      chk("t2_pulses", pulses, N);

      // in_valid kept high after all words accepted
      repeat (5) drive_tick();
      chk("t3_pulses", pulses, N);
      chk("t3_ready_low", in_ready, 0);

      // Abort with start in the same cycle after 40 sends
      pulse_start();
      begin
         int n;
         n = 0;
         while (pulses < 40 && n < 1000) begin
            in_valid = ($urandom_range(3) != 0);
            drive_tick();
            n++;
         end
      end
      chk("t4_pre_abort", pulses, 40);
      in_valid = 1'b1;
      abort = 1'b1;
      start = 1'b1;
      drive_tick();
      abort = 1'b0;
      start = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_enable", sender_enable, 0);
      chk("t4_count", node_count, 0);
      chk("t4_ready", in_ready, 0);
      pulse_start();
      run_to_done("t4_reload_done");
      chk("t4_reload_pulses", pulses, N);

      // Asynchronous reset mid-stream
      pulse_start();
      repeat (30) drive_tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_ready", in_ready, 0);
      chk("t5_enable", sender_enable, 0);
      chk("t5_data", sender_data, 0);
      chk("t5_count", node_count, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) drive_tick();
      chk("t5_idle", busy, 0);
      pulse_start();
      run_to_done("t5_load_done");

      // Random traffic with random data, pause and rare aborts
      seq_on = 0;
      for (int ld = 0; ld < 4; ld++) begin
         int n;
         pulse_start();
         n = 0;
         while (m_mode == 1 && n < 3000) begin
            in_valid = ($urandom_range(3) != 0);
            pause = ($urandom_range(3) == 0);
            in_data = W'($urandom);
            abort = ($urandom_range(399) == 0);
            tick();
            n++;
         end
         abort = 1'b0;
         pause = 1'b0;
         chk("rand_finished", n < 3000, 1);
         if (m_mode == 2) chk("rand_pulses", pulses, N);
         repeat (2) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
